// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_pkg
// Brief    : Shared types and requester tags for the L2 port arbiter.
// Revision : 1.0
// ============================================================================
package l2_port_arbiter_pkg;

    localparam int   L2_ADDR_WIDTH = 32;
    localparam logic L2_ID_I       = 1'b0;
    localparam logic L2_ID_D       = 1'b1;

    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0] paddr;
        logic                     id;
    } l2_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } l2_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin pick with one-hot grant.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import l2_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // Bit 0 is the I-side, bit 1 the D-side; a tie goes to the side that lost last time.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last == L2_ID_D) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Brief    : Serializes I-side and D-side misses onto the single L2 port.
// Revision : 1.0
// ============================================================================
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_paddr,
    output logic                  o_i_resp,
    output logic                  o_i_err,
    output logic [DATA_WIDTH-1:0] o_i_data,
    input  logic                  i_d_req,
    input  logic [ADDR_WIDTH-1:0] i_d_paddr,
    output logic                  o_d_resp,
    output logic                  o_d_err,
    output logic [DATA_WIDTH-1:0] o_d_data,
    output logic                  o_l2_req,
    output logic [ADDR_WIDTH-1:0] o_l2_paddr,
    output logic                  o_l2_id,
    input  logic                  i_l2_ack,
    input  logic                  i_l2_resp,
    input  logic                  i_l2_err,
    input  logic [DATA_WIDTH-1:0] i_l2_data,
    input  logic [31:0]           i_log_fd
);

    l2_arb_state_t         r_state;
    l2_arb_state_t         w_state_nxt;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_grant;
    logic                  w_win_id;
    logic [ADDR_WIDTH-1:0] w_win_paddr;
    logic                  w_drop_now;
    logic                  r_last;
    logic                  r_drop;
    logic                  r_l2_req;
    logic [ADDR_WIDTH-1:0] r_l2_paddr;
    logic                  r_l2_id;
    logic                  r_i_resp;
    logic                  r_i_err;
    logic [DATA_WIDTH-1:0] r_i_data;
    logic                  r_d_resp;
    logic                  r_d_err;
    logic [DATA_WIDTH-1:0] r_d_data;

    assign w_req = {i_d_req, i_i_req & ~i_flush};

    rr_arb2 u_rr_arb2 (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign w_grant     = |w_gnt;
    assign w_win_id    = w_gnt[1] ? L2_ID_D : L2_ID_I;
    assign w_win_paddr = w_gnt[1] ? i_d_paddr : i_i_paddr;
    // A flush landing on the response cycle itself must still drop it.
    assign w_drop_now  = r_drop | (i_flush & (r_l2_id == L2_ID_I));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant)   w_state_nxt = REQ;
            REQ:     if (i_l2_ack)  w_state_nxt = WAIT;
            WAIT:    if (i_l2_resp) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last     <= L2_ID_D;
            r_drop     <= 1'b0;
            r_l2_req   <= 1'b0;
            r_l2_paddr <= '0;
            r_l2_id    <= L2_ID_I;
            r_i_resp   <= 1'b0;
            r_i_err    <= 1'b0;
            r_i_data   <= '0;
            r_d_resp   <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_data   <= '0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant) begin
                        r_l2_req   <= 1'b1;
                        r_l2_paddr <= w_win_paddr;
                        r_l2_id    <= w_win_id;
                        r_last     <= w_win_id;
                    end
                end
                REQ: begin
                    if (i_l2_ack) r_l2_req <= 1'b0;
                    if (i_flush && r_l2_id == L2_ID_I) r_drop <= 1'b1;
                end
                WAIT: begin
                    if (i_flush && r_l2_id == L2_ID_I) r_drop <= 1'b1;
                    if (i_l2_resp) begin
                        if (r_l2_id == L2_ID_D) begin
                            r_d_resp <= 1'b1;
                            r_d_err  <= i_l2_err;
                            r_d_data <= i_l2_data;
                        end else if (!w_drop_now) begin
                            r_i_resp <= 1'b1;
                            r_i_err  <= i_l2_err;
                            r_i_data <= i_l2_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_l2_req   = r_l2_req;
    assign o_l2_paddr = r_l2_paddr;
    assign o_l2_id    = r_l2_id;
    assign o_i_resp   = r_i_resp;
    assign o_i_err    = r_i_err;
    assign o_i_data   = r_i_data;
    assign o_d_resp   = r_d_resp;
    assign o_d_err    = r_d_err;
    assign o_d_data   = r_d_data;

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_l2_resp && r_state != WAIT))
                else $error("[L2A] i_l2_resp outside WAIT");
            // A live, undropped I-side owner must keep its request up until the response.
            assert (!(r_state != IDLE && r_l2_id == L2_ID_I && !r_drop && !i_flush && !i_i_req))
                else $error("[L2A] I-side request withdrawn before response");
            if (i_log_fd != 32'd0) begin
                if (r_state == IDLE && w_grant)
                    $display("[L2A] grant id=%0d paddr=%h", w_win_id, w_win_paddr);
                if (r_state == WAIT && i_l2_resp)
                    $display("[L2A] resp id=%0d err=%0d drop=%0d data=%h",
                             r_l2_id, i_l2_err, (r_l2_id == L2_ID_I) && w_drop_now, i_l2_data);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Brief    : Self-checking bench for l2_port_arbiter with an L2 responder model.
// Revision : 1.0
// ============================================================================
module tb_l2_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          l2_ack = 1'b0;
    logic          l2_resp = 1'b0;
    logic          l2_err = 1'b0;
    logic [DW-1:0] l2_data = '0;
    logic [31:0]   log_fd = 32'd0;
    logic          i_resp, i_err, d_resp, d_err;
    logic [DW-1:0] i_data, d_data;
    logic          l2_req, l2_id;
    logic [AW-1:0] l2_paddr;

    int            errors = 0;
    int            checks = 0;
    logic          m_last = 1'b1;      // previous grant owner; D after reset
    logic          fl_new_pend = 1'b0;
    logic [AW-1:0] fl_new_addr = '0;

    l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_i_req    (i_req),
        .i_i_paddr  (i_addr),
        .o_i_resp   (i_resp),
        .o_i_err    (i_err),
        .o_i_data   (i_data),
        .i_d_req    (d_req),
        .i_d_paddr  (d_addr),
        .o_d_resp   (d_resp),
        .o_d_err    (d_err),
        .o_d_data   (d_data),
        .o_l2_req   (l2_req),
        .o_l2_paddr (l2_paddr),
        .o_l2_id    (l2_id),
        .i_l2_ack   (l2_ack),
        .i_l2_resp  (l2_resp),
        .i_l2_err   (l2_err),
        .i_l2_data  (l2_data),
        .i_log_fd   (log_fd)
    );

    always #5 clk = ~clk;

    // Round-robin rule: a tie goes to whoever did not win last; otherwise the lone requester.
    function automatic logic pick(input logic vi, input logic vd, input logic last);
        if (vi && vd) return !last;
        return vd;
    endfunction

    // Advance to the next falling edge; a flush pulse lasts exactly one cycle.
    task automatic step();
        @(negedge clk);
        if (flush) begin
            flush = 1'b0;
            if (fl_new_pend) begin
                i_req       = 1'b1;
                i_addr      = fl_new_addr;
                fl_new_pend = 1'b0;
            end
        end
    endtask

    task automatic do_flush(input logic nw, input logic [AW-1:0] a);
        flush       = 1'b1;
        i_req       = 1'b0;
        fl_new_pend = nw;
        fl_new_addr = a;
    endtask

    // One full L2 transaction; fl_phase 0=REQ, 1=WAIT, 2=with response, 3=none.
    task automatic l2_txn(input int ack_dly, input int resp_dly, input int fl_phase,
                          input logic fl_nw, input logic [AW-1:0] fl_a,
                          input logic err, input logic [DW-1:0] data);
        logic          exp_id;
        logic          exp_drop;
        logic [AW-1:0] exp_addr;
        int            waited;
        exp_id   = pick(i_req, d_req, m_last);
        exp_addr = exp_id ? d_addr : i_addr;
        m_last   = exp_id;
        exp_drop = (exp_id == 1'b0) && (fl_phase < 3);
        waited   = 0;
        do begin
            step();
            waited++;
        end while (!l2_req && waited < 20);
        checks++;
        if (l2_req !== 1'b1 || waited != 1 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL grant_latency: l2_req=%0b after %0d cycles (i_resp=%0b d_resp=%0b), required l2_req=1 after 1 cycle, no resp",
                     l2_req, waited, i_resp, d_resp);
        end
        checks++;
        if (l2_paddr !== exp_addr || l2_id !== exp_id) begin
            errors++;
            $display("FAIL grant_target: paddr=%h id=%0b, required paddr=%h id=%0b",
                     l2_paddr, l2_id, exp_addr, exp_id);
        end
        if (fl_phase == 0) do_flush(fl_nw, fl_a);
        for (int k = 0; k < ack_dly; k++) begin
            step();
            checks++;
            if (l2_req !== 1'b1 || l2_paddr !== exp_addr) begin
                errors++;
                $display("FAIL req_hold: l2_req=%0b paddr=%h, required 1 and %h", l2_req, l2_paddr, exp_addr);
            end
        end
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        checks++;
        if (l2_req !== 1'b0) begin
            errors++;
            $display("FAIL req_release: l2_req=%0b, required 0", l2_req);
        end
        if (fl_phase == 1) do_flush(fl_nw, fl_a);
        for (int k = 0; k < resp_dly; k++) begin
            step();
            checks++;
            if (l2_req !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
                errors++;
                $display("FAIL wait_quiet: l2_req=%0b i_resp=%0b d_resp=%0b, required all 0",
                         l2_req, i_resp, d_resp);
            end
        end
        if (fl_phase == 2) do_flush(fl_nw, fl_a);
        l2_resp = 1'b1;
        l2_err  = err;
        l2_data = data;
        step();
        l2_resp = 1'b0;
        l2_err  = 1'b0;
        checks++;
        if (exp_id) begin
            if (d_resp !== 1'b1 || d_err !== err || d_data !== data || i_resp !== 1'b0) begin
                errors++;
                $display("FAIL d_resp: d_resp=%0b err=%0b data=%h i_resp=%0b, required 1 %0b %h 0",
                         d_resp, d_err, d_data, i_resp, err, data);
            end
            d_req = 1'b0;
        end else if (exp_drop) begin
            if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
                errors++;
                $display("FAIL drop: i_resp=%0b d_resp=%0b, required 0 0", i_resp, d_resp);
            end
        end else begin
            if (i_resp !== 1'b1 || i_err !== err || i_data !== data || d_resp !== 1'b0) begin
                errors++;
                $display("FAIL i_resp: i_resp=%0b err=%0b data=%h d_resp=%0b, required 1 %0b %h 0",
                         i_resp, i_err, i_data, d_resp, err, data);
            end
            i_req = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (l2_req !== 1'b0 || l2_paddr !== '0 || l2_id !== 1'b0 || i_resp !== 1'b0 ||
            d_resp !== 1'b0 || i_err !== 1'b0 || d_err !== 1'b0 || i_data !== '0 || d_data !== '0) begin
            errors++;
            $display("FAIL %s: req=%0b paddr=%h id=%0b iresp=%0b dresp=%0b ierr=%0b derr=%0b idata=%h ddata=%h, required all 0",
                     name, l2_req, l2_paddr, l2_id, i_resp, d_resp, i_err, d_err, i_data, d_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset_values");
        rst_n  = 1'b1;
        m_last = 1'b1;
        step();
        checks++;
        if (l2_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: l2_req=%0b, required 0", l2_req);
        end
    endtask

    task automatic test_tie();
        i_req = 1'b1; i_addr = 32'h2000;
        d_req = 1'b1; d_addr = 32'h3000;
        l2_txn(0, 0, 3, 1'b0, '0, 1'b0, 64'h1111_0000_0000_2000);
        l2_txn(1, 0, 3, 1'b0, '0, 1'b0, 64'h1111_0000_0000_3000);
        i_req = 1'b1; i_addr = 32'h2400;
        d_req = 1'b1; d_addr = 32'h3400;
        l2_txn(0, 1, 3, 1'b0, '0, 1'b0, 64'h2222_0000_0000_2400);
        i_req = 1'b1; i_addr = 32'h2800;
        l2_txn(0, 0, 3, 1'b0, '0, 1'b0, 64'h2222_0000_0000_3400);
        l2_txn(0, 0, 3, 1'b0, '0, 1'b0, 64'h2222_0000_0000_2800);
    endtask

    task automatic test_single_i();
        i_req = 1'b1; i_addr = 32'h1000;
        l2_txn(2, 1, 3, 1'b0, '0, 1'b0, 64'hDEAD_BEEF_0000_0001);
    endtask

    task automatic test_flush();
        i_req = 1'b1; i_addr = 32'h5000;
        l2_txn(1, 2, 1, 1'b1, 32'h4000, 1'b0, 64'h5555_5555_5555_5555);
        l2_txn(0, 1, 3, 1'b0, '0, 1'b0, 64'h4444_0000_0000_4000);
        i_req = 1'b1; i_addr = 32'h6000;
        l2_txn(2, 1, 0, 1'b0, '0, 1'b0, 64'h6666_6666_6666_6666);
        i_req = 1'b1; i_addr = 32'h6800;
        l2_txn(0, 1, 2, 1'b0, '0, 1'b0, 64'h6868_6868_6868_6868);
        i_req = 1'b1; i_addr = 32'h7000; flush = 1'b1;
        step();
        checks++;
        if (l2_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_grant: l2_req=%0b, required 0", l2_req);
        end
        l2_txn(0, 0, 3, 1'b0, '0, 1'b0, 64'h7777_0000_0000_7000);
    endtask

    task automatic test_d_err();
        d_req = 1'b1; d_addr = 32'h8000;
        l2_txn(1, 1, 3, 1'b0, '0, 1'b1, 64'h8888_0000_0000_8000);
    endtask

    task automatic test_reset_wait();
        d_req = 1'b1; d_addr = 32'h9000;
        step();
        checks++;
        if (l2_req !== 1'b1 || l2_paddr !== 32'h9000) begin
            errors++;
            $display("FAIL rst_setup: l2_req=%0b paddr=%h, required 1 00009000", l2_req, l2_paddr);
        end
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        rst_n  = 1'b0;
        d_req  = 1'b0;
        step();
        check_all_zero("reset_in_wait");
        rst_n  = 1'b1;
        m_last = 1'b1;
        step();
        checks++;
        if (l2_req !== 1'b0 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: l2_req=%0b d_resp=%0b, required 0 0", l2_req, d_resp);
        end
        d_req = 1'b1; d_addr = 32'hA000;
        l2_txn(0, 0, 3, 1'b0, '0, 1'b0, 64'hAAAA_0000_0000_A000);
    endtask

    task automatic test_random();
        int ph;
        for (int n = 0; n < 40; n++) begin
            if (!i_req && $urandom_range(1, 0) == 1) begin
                i_req = 1'b1; i_addr = {$urandom_range(16'hFFFF, 0), 16'h0} | 32'h40;
            end
            if (!d_req && $urandom_range(1, 0) == 1) begin
                d_req = 1'b1; d_addr = {$urandom_range(16'hFFFF, 0), 16'h0} | 32'h80;
            end
            if (!i_req && !d_req) begin
                d_req = 1'b1; d_addr = $urandom() & 32'hFFFF_FFC0;
            end
            ph = ($urandom_range(3, 0) == 0) ? $urandom_range(2, 0) : 3;
            l2_txn($urandom_range(3, 0), $urandom_range(3, 0), ph,
                   1'(($urandom_range(1, 0))), $urandom() & 32'hFFFF_FFC0,
                   1'(($urandom_range(1, 0))), {$urandom(), $urandom()});
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_i();
        test_flush();
        test_d_err();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
